ecc_apb_regfile: RTL

APB responder and register bank for the ECC encoder/decoder core. It decodes the bus writes issued by the APB initiator and latches the CTRL, DATA_IN, CODEWORD_WIDTH and NOISE registers. A CTRL write fires a one-cycle start pulse to the core and holds the bank busy until the core reports completion. It captures the core's data_out and num_of_errors results and returns them on APB reads.

---
 rtl/ecc_pkg.sv | 18 +
 rtl/apb_slave_fsm.sv | 66 ++++++
 rtl/ecc_apb_regfile.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC APB register bank: address map, FSM state types and CTRL encodings.
package ecc_pkg;

    localparam logic [31:0] ADDR_CTRL     = 32'h0000_0000;
    localparam logic [31:0] ADDR_DATA_IN  = 32'h0000_0004;
    localparam logic [31:0] ADDR_CW       = 32'h0000_0008;
    localparam logic [31:0] ADDR_NOISE    = 32'h0000_000C;
    localparam logic [31:0] ADDR_DATA_OUT = 32'h0000_0010;
    localparam logic [31:0] ADDR_STATUS   = 32'h0000_0014;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
    typedef enum logic {READY, BUSY} core_state_t;

    localparam logic [1:0] ENC  = 2'd0;
    localparam logic [1:0] DEC  = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB responder protocol FSM: tracks IDLE/SETUP/ACCESS and produces write/read strobes for the bank.
//
// state  | meaning
// IDLE   | no transfer in progress
// SETUP  | setup phase seen, waiting for penable
// ACCESS | access phase done; a pending write commits on this cycle's edge
module apb_slave_fsm
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic                       wr_en,
    output logic                       rd_en,
    output logic [AMBA_ADDR_WIDTH-1:0] addr,
    output logic [AMBA_WORD-1:0]       wdata
);

    apb_state_t state, state_next;
    logic       write_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            write_q <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
        end else begin
            state <= state_next;
            // Bus may already be moving on when the commit edge arrives, so hold the transfer.
            if (state == SETUP && psel && penable) begin
                write_q <= pwrite;
                addr    <= paddr;
                wdata   <= pwdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (psel && !penable) ? SETUP : IDLE;
            SETUP: begin
                if (psel && penable)
                    state_next = ACCESS;
                else if (psel)
                    state_next = SETUP;
                else
                    state_next = IDLE;
            end
            ACCESS:  state_next = (psel && !penable) ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign wr_en = (state == ACCESS) && write_q;
    assign rd_en = psel && !penable && !pwrite;

endmodule

// File: rtl/ecc_apb_regfile.sv
// APB register bank for the ECC core: config registers, start/busy handshake and result capture.
// Define ECC_REG_READBACK_EN to make CTRL/DATA_IN/CODEWORD_WIDTH/NOISE readable.
module ecc_apb_regfile
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic [AMBA_WORD-1:0]       prdata,
    output logic [1:0]                 ctrl,
    output logic [DATA_WIDTH-1:0]      data_in,
    output logic [1:0]                 codeword_width,
    output logic [AMBA_WORD-1:0]       noise,
    output logic                       start,
    input  logic                       core_done,
    input  logic [DATA_WIDTH-1:0]      core_data_out,
    input  logic [1:0]                 core_num_of_errors,
    output logic                       operation_done
);

    localparam logic [AMBA_ADDR_WIDTH-1:0] A_CTRL     = AMBA_ADDR_WIDTH'(ADDR_CTRL);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_DATA_IN  = AMBA_ADDR_WIDTH'(ADDR_DATA_IN);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_CW       = AMBA_ADDR_WIDTH'(ADDR_CW);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_NOISE    = AMBA_ADDR_WIDTH'(ADDR_NOISE);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_DATA_OUT = AMBA_ADDR_WIDTH'(ADDR_DATA_OUT);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_STATUS   = AMBA_ADDR_WIDTH'(ADDR_STATUS);

    logic                       wr_en, rd_en;
    logic [AMBA_ADDR_WIDTH-1:0] addr;
    logic [AMBA_WORD-1:0]       wdata;
    logic [AMBA_WORD-1:0]       rd_word;
    logic [DATA_WIDTH-1:0]      data_out_q;
    logic [1:0]                 errors_q;
    logic                       busy, start_set;
    core_state_t                core_state, core_next;

    apb_slave_fsm #(
        .AMBA_WORD       (AMBA_WORD),
        .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (addr),
        .wdata   (wdata)
    );

    assign busy = (core_state == BUSY);

    always_ff @(posedge clk) begin
        if (rst) core_state <= READY;
        else     core_state <= core_next;
    end

    always_comb begin
        core_next = core_state;
        start_set = 1'b0;
        case (core_state)
            READY: begin
                if (wr_en && addr == A_CTRL && wdata[1:0] != 2'd3) begin
                    core_next = BUSY;
                    start_set = 1'b1;
                end
            end
            BUSY:    if (core_done) core_next = READY;
            default: core_next = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl           <= ENC;
            data_in        <= '0;
            codeword_width <= '0;
            noise          <= '0;
            start          <= 1'b0;
            operation_done <= 1'b0;
            data_out_q     <= '0;
            errors_q       <= '0;
            prdata         <= '0;
        end else begin
            start <= start_set;
            // Configuration is frozen for the whole time the core is working.
            if (wr_en && !busy) begin
                case (addr)
                    A_CTRL:    if (wdata[1:0] != 2'd3) ctrl <= wdata[1:0];
                    A_DATA_IN: data_in        <= wdata[DATA_WIDTH-1:0];
                    A_CW:      codeword_width <= wdata[1:0];
                    A_NOISE:   noise          <= wdata;
                    default:   ;
                endcase
            end
            if (start_set)
                operation_done <= 1'b0;
            if (busy && core_done) begin
                data_out_q     <= core_data_out;
                errors_q       <= core_num_of_errors;
                operation_done <= 1'b1;
            end
            if (rd_en)
                prdata <= rd_word;
        end
    end

    always_comb begin
        rd_word = '0;
        case (paddr)
`ifdef ECC_REG_READBACK_EN
            A_CTRL:     rd_word[1:0]            = ctrl;
            A_DATA_IN:  rd_word[DATA_WIDTH-1:0] = data_in;
            A_CW:       rd_word[1:0]            = codeword_width;
            A_NOISE:    rd_word                 = noise;
`endif
            A_DATA_OUT: rd_word[DATA_WIDTH-1:0] = data_out_q;
            A_STATUS:   rd_word[3:0]            = {errors_q, busy, operation_done};
            default:    ;
        endcase
    end

endmodule
